// File: rtl/nibble_add_sched.sv
// nibble_add_sched: round-robin scheduler for two requesters sharing one nibble-serial 4-bit add/sub datapath.
// Latency: grant edge to ack pulse is NIBBLES cycles; busy for NIBBLES+1 cycles; at least one IDLE cycle between operations.
// Backpressure: req is held until ack; requests arriving in ADD/DONE wait; a served requester re-arms only after req is seen low.
//
// Ports:
//   clock, resetn          single clock, asynchronous active-low reset
//   req0/req1              request lines, held high until the matching ack
//   a0,b0,sub0 / a1,b1,sub1 operands and op select per requester (sub=1: a-b)
//   ack0/ack1              one-cycle completion pulse to the served requester
//   result, cout, ovf      outcome of the last completed operation (held until the next one)
//   busy, owner            operation in progress and index of the granted requester
module nibble_add_sched #(
    parameter int NIBBLES = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 req0,
    input  logic                 req1,
    input  logic [4*NIBBLES-1:0] a0,
    input  logic [4*NIBBLES-1:0] b0,
    input  logic [4*NIBBLES-1:0] a1,
    input  logic [4*NIBBLES-1:0] b1,
    input  logic                 sub0,
    input  logic                 sub1,
    output logic                 ack0,
    output logic                 ack1,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy,
    output logic                 owner
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT            state;
    logic [1:0]       armed;      // per requester: eligible for a grant
    logic             rrPrio;     // requester that wins a tie
    logic [W-1:0]     opA;
    logic [W-1:0]     opB;
    logic             opSub;
    logic             carry;
    logic [W-1:0]     shadow;     // result under construction, not yet visible
    logic [IDXW-1:0]  idx;

    logic             want0;
    logic             want1;
    logic             grantSel;
    logic [IDXW+1:0]  bitBase;
    logic [3:0]       nibA;
    logic [3:0]       nibB;
    logic [3:0]       prop;
    logic [3:0]       nibSum;
    logic [4:0]       chain;
    logic [W-1:0]     nextShadow;
    logic             lastNib;
    logic             ovfNext;

    assign want0    = req0 & armed[0];
    assign want1    = req1 & armed[1];
    // Tie goes to rrPrio; otherwise whichever requester is asking.
    assign grantSel = (want0 & want1) ? rrPrio : want1;
    assign bitBase  = {idx, 2'b00};

    // The single shared 4-bit adder. Carry uses the XOR-select mux form:
    // when a^b propagates, pass the incoming carry, otherwise a (== b) is the carry.
    always_comb begin
        nibSum     = '0;
        chain      = '0;
        nibA       = opA[bitBase +: 4];
        nibB       = opB[bitBase +: 4] ^ {4{opSub}};
        prop       = nibA ^ nibB;
        chain[0]   = carry;
        for (int k = 0; k < 4; k++) begin
            nibSum[k]   = prop[k] ^ chain[k];
            chain[k+1]  = prop[k] ? chain[k] : nibA[k];
        end
        nextShadow              = shadow;
        nextShadow[bitBase +: 4] = nibSum;
        lastNib  = (idx == IDXW'(NIBBLES - 1));
        // Only meaningful on the MSB nibble: same-sign operands, result sign flipped.
        ovfNext  = (opA[W-1] == (opB[W-1] ^ opSub)) && (nibSum[3] != opA[W-1]);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            ack0   <= 1'b0;
            ack1   <= 1'b0;
            busy   <= 1'b0;
            owner  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            armed  <= 2'b11;
            rrPrio <= 1'b0;
            opA    <= '0;
            opB    <= '0;
            opSub  <= 1'b0;
            carry  <= 1'b0;
            shadow <= '0;
            idx    <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;

            // A low req re-arms its requester; the disarm on completion below takes precedence.
            if (!req0) armed[0] <= 1'b1;
            if (!req1) armed[1] <= 1'b1;

            case (state)
                IDLE: begin
                    if (want0 || want1) begin
                        owner  <= grantSel;
                        busy   <= 1'b1;
                        opA    <= grantSel ? a1 : a0;
                        opB    <= grantSel ? b1 : b0;
                        opSub  <= grantSel ? sub1 : sub0;
                        carry  <= grantSel ? sub1 : sub0;
                        idx    <= '0;
                        rrPrio <= ~grantSel;
                        state  <= ADD;
                    end
                end

                ADD: begin
                    shadow <= nextShadow;
                    carry  <= chain[4];
                    idx    <= idx + IDXW'(1);
                    if (lastNib) begin
                        result       <= nextShadow;
                        cout         <= chain[4];
                        ovf          <= ovfNext;
                        ack0         <= ~owner;
                        ack1         <= owner;
                        armed[owner] <= 1'b0;
                        state        <= DONE;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_add_sched.sv
// tb_nibble_add_sched: directed table-driven bench for nibble_add_sched with hand-computed results.
// Latency: expects ack NIBBLES cycles after the grant edge (NIBBLES+1 falling edges after raising req in IDLE).
// Backpressure: exercises ties, re-arm after ack, requests waiting during an operation, and reset mid-operation.
module tb_nibble_add_sched;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clock;
    logic         resetn;
    logic         req0, req1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         sub0, sub1;
    logic         ack0, ack1;
    logic [W-1:0] result;
    logic         cout, ovf, busy, owner;

    int tests;
    int fails;
    int dblAck;

    nibble_add_sched #(.NIBBLES(NIB)) dut (
        .clock  (clock),
        .resetn (resetn),
        .req0   (req0),
        .req1   (req1),
        .a0     (a0),
        .b0     (b0),
        .a1     (a1),
        .b1     (b1),
        .sub0   (sub0),
        .sub1   (sub1),
        .ack0   (ack0),
        .ack1   (ack1),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .busy   (busy),
        .owner  (owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (ack0 && ack1) dblAck++;
    end

    typedef struct {
        logic         sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] expRes;
        logic         expCout;
        logic         expOvf;
    } vecT;

    vecT vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic setOps(input logic sel, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        if (sel) begin
            a1 = a; b1 = b; sub1 = s;
        end else begin
            a0 = a; b0 = b; sub0 = s;
        end
    endtask

    // Waits (bounded) for an ack; scr selects whose operands get corrupted right after the grant (2 = none).
    task automatic waitAck(input int scr, output int which, output int cyc, output int busyCnt);
        which   = -1;
        cyc     = 0;
        busyCnt = 0;
        while (which < 0 && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (busy) busyCnt++;
            if (cyc == 1 && scr == 0) begin
                a0 = ~a0; b0 = ~b0; sub0 = ~sub0;
            end
            if (cyc == 1 && scr == 1) begin
                a1 = ~a1; b1 = ~b1; sub1 = ~sub1;
            end
            if (ack0) which = 0;
            else if (ack1) which = 1;
        end
    endtask

    task automatic doOp(input vecT v, input int n);
        int which, cyc, bc;
        @(negedge clock);
        setOps(v.sel, v.a, v.b, v.sub);
        if (v.sel) req1 = 1'b1; else req0 = 1'b1;
        waitAck(int'(v.sel), which, cyc, bc);
        chk($sformatf("vec%0d_ack", n),     which, int'(v.sel));
        chk($sformatf("vec%0d_latency", n), cyc, NIB + 1);
        chk($sformatf("vec%0d_busy", n),    bc, NIB + 1);
        chk($sformatf("vec%0d_owner", n),   owner, v.sel);
        chk($sformatf("vec%0d_result", n),  result, v.expRes);
        chk($sformatf("vec%0d_cout", n),    cout, v.expCout);
        chk($sformatf("vec%0d_ovf", n),     ovf, v.expOvf);
        if (v.sel) req1 = 1'b0; else req0 = 1'b0;
    endtask

    initial begin
        int which, cyc, bc, idleBusy;
        tests  = 0;
        fails  = 0;
        dblAck = 0;

        //          sel   a        b        sub   result   cout  ovf
        vecs[0] = '{1'b0, 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 16'h5555, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0};

        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; sub0 = 1'b0; sub1 = 1'b0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        chk("rst_busy",   busy, 0);
        chk("rst_ack0",   ack0, 0);
        chk("rst_ack1",   ack1, 0);
        chk("rst_owner",  owner, 0);
        chk("rst_result", result, 0);
        chk("rst_cout",   cout, 0);
        chk("rst_ovf",    ovf, 0);

        // Tie from reset: 0 first, then 1, then 0 again.
        setOps(1'b0, 16'h1234, 16'h0FCD, 1'b0);
        setOps(1'b1, 16'h8000, 16'h0001, 1'b1);
        req0 = 1'b1; req1 = 1'b1;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        waitAck(2, which, cyc, bc);
        chk("tie1_ack",     which, 0);
        chk("tie1_latency", cyc, NIB + 1);
        chk("tie1_result",  result, 16'h2201);
        req0 = 1'b0;
        waitAck(2, which, cyc, bc);
        chk("tie2_ack",     which, 1);
        chk("tie2_result",  result, 16'h7FFF);
        chk("tie2_cout",    cout, 1);
        chk("tie2_ovf",     ovf, 1);
        req1 = 1'b0;
        @(negedge clock);
        req0 = 1'b1; req1 = 1'b1;
        waitAck(2, which, cyc, bc);
        chk("tie3_ack",     which, 0);
        chk("tie3_result",  result, 16'h2201);
        req0 = 1'b0; req1 = 1'b0;

        for (int i = 0; i < 9; i++) doOp(vecs[i], i);

        // Re-arm: req0 held high after ack0 must not be granted again.
        @(negedge clock);
        setOps(1'b0, 16'h0102, 16'h0304, 1'b0);
        req0 = 1'b1;
        waitAck(2, which, cyc, bc);
        chk("rearm_first_ack", which, 0);
        chk("rearm_first_res", result, 16'h0406);
        @(negedge clock);
        idleBusy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (busy || ack0) idleBusy++;
        end
        chk("rearm_held_no_grant", idleBusy, 0);
        req0 = 1'b0;
        @(negedge clock);
        req0 = 1'b1;
        setOps(1'b0, 16'h1000, 16'h0001, 1'b1);
        waitAck(2, which, cyc, bc);
        chk("rearm_regrant_ack",     which, 0);
        chk("rearm_regrant_latency", cyc, NIB + 1);
        chk("rearm_regrant_res",     result, 16'h0FFF);

        // req0 still held; req1 shows up while req0 is low, req0 comes back and must wait its turn.
        @(negedge clock);
        idleBusy = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (busy) idleBusy++;
        end
        chk("rearm_held2_no_grant", idleBusy, 0);
        setOps(1'b1, 16'h0020, 16'h0003, 1'b0);
        setOps(1'b0, 16'h1234, 16'h0FCD, 1'b0);
        req0 = 1'b0; req1 = 1'b1;
        @(negedge clock);
        req0 = 1'b1;
        waitAck(2, which, cyc, bc);
        chk("order_first_ack", which, 1);
        chk("order_first_res", result, 16'h0023);
        req1 = 1'b0;
        waitAck(2, which, cyc, bc);
        chk("order_second_ack", which, 0);
        chk("order_second_res", result, 16'h2201);
        req0 = 1'b0;

        // Reset in the second ADD cycle of a fresh operation.
        @(negedge clock);
        @(negedge clock);
        setOps(1'b1, 16'h4444, 16'h1111, 1'b1);
        req1 = 1'b1;
        waitAck(2, which, cyc, bc);
        chk("pre_reset_ack", which, 1);
        chk("pre_reset_res", result, 16'h3333);
        req1 = 1'b0;
        @(negedge clock);
        setOps(1'b0, 16'h1234, 16'h0FCD, 1'b0);
        req0 = 1'b1;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        chk("midrst_busy",   busy, 0);
        chk("midrst_ack0",   ack0, 0);
        chk("midrst_ack1",   ack1, 0);
        chk("midrst_owner",  owner, 0);
        chk("midrst_result", result, 0);
        chk("midrst_cout",   cout, 0);
        chk("midrst_ovf",    ovf, 0);
        @(negedge clock);
        chk("midrst_no_ack", {30'd0, ack1, ack0}, 0);
        resetn = 1'b1;
        waitAck(2, which, cyc, bc);
        chk("postrst_ack",     which, 0);
        chk("postrst_latency", cyc, NIB + 1);
        chk("postrst_result",  result, 16'h2201);
        chk("postrst_cout",    cout, 0);
        chk("postrst_ovf",     ovf, 0);
        req0 = 1'b0;

        // Outputs hold between operations even when operands change.
        setOps(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        setOps(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        for (int i = 0; i < 5; i++) @(negedge clock);
        chk("hold_result", result, 16'h2201);
        chk("hold_busy",   busy, 0);

        chk("no_double_ack", dblAck, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
